// File: rtl/lpc_reg_wr_arb_if.sv
// Purpose: bundles the host write, internal request and shared register-bank
//          write signals of lpc_reg_wr_arb.
// Signals:
//   HostWr/HostAddr/HostData  LPC host register write (one-cycle strobe)
//   Req[1:0]                  internal write requests, level, held until Gnt
//   ReqAddr0/1, ReqData0/1    internal request address/data
//   RegWr/RegAddr/RegData     shared register-bank write port
//   Gnt[1:0], Abort[1:0]      per-requester completion / drop pulses
// Modports: master drives the requests, slave is the arbiter.
interface lpc_reg_wr_arb_if;
    logic       HostWr;
    logic [7:0] HostAddr;
    logic [7:0] HostData;
    logic [1:0] Req;
    logic [7:0] ReqAddr0;
    logic [7:0] ReqAddr1;
    logic [7:0] ReqData0;
    logic [7:0] ReqData1;
    logic       RegWr;
    logic [7:0] RegAddr;
    logic [7:0] RegData;
    logic [1:0] Gnt;
    logic [1:0] Abort;

    modport master (
        output HostWr, HostAddr, HostData, Req, ReqAddr0, ReqAddr1, ReqData0, ReqData1,
        input  RegWr, RegAddr, RegData, Gnt, Abort
    );

    modport slave (
        input  HostWr, HostAddr, HostData, Req, ReqAddr0, ReqAddr1, ReqData0, ReqData1,
        output RegWr, RegAddr, RegData, Gnt, Abort
    );
endinterface

// File: rtl/lpc_reg_wr_arb.sv
// Purpose: arbitrates the shared register-bank write port between the LPC host
//          (absolute priority, never stalls) and two internal requesters served
//          round-robin, with a programmable idle gap after each internal write
//          and an abort path when the host already wrote the requested address.
// Ports:
//   LpcClock  33 MHz LPC clock, rising edge
//   PciReset  asynchronous active-low reset
//   bus       lpc_reg_wr_arb_if.slave (host write, requests, register write, Gnt/Abort)
// Parameter GAP: idle cycles after each internal write commit, 0-7.
module lpc_reg_wr_arb #(
    parameter int unsigned GAP = 1
) (
    input  logic           LpcClock,
    input  logic           PciReset,
    lpc_reg_wr_arb_if.slave bus
);

    localparam int unsigned CntW    = 3;
    localparam logic [CntW-1:0] GapLoad = (GAP == 0) ? '0 : CntW'(GAP - 1);

    typedef enum logic {
        StIdle = 1'b0,
        StGap  = 1'b1
    } state_t;

    state_t          state, stateNext;
    logic [CntW-1:0] gapCnt, gapCntNext;
    logic            ptr, ptrNext;
    logic [1:0]      conf, confNext;
    logic [1:0]      eligible;
    logic [1:0]      hostHit;
    logic            selValid;
    logic            sel;
    logic            selAbort;

    logic            regWrQ, regWrNext;
    logic [7:0]      regAddrQ, regAddrNext;
    logic [7:0]      regDataQ, regDataNext;
    logic [1:0]      gntQ, gntNext;
    logic [1:0]      abortQ, abortNext;

    // Request selection; a requester being granted this cycle is not eligible.
    always_comb begin
        eligible = bus.Req & ~gntQ;
        selValid = (state == StIdle) && !bus.HostWr && (|eligible);
        sel      = eligible[ptr] ? ptr : ~ptr;
        selAbort = conf[sel];
    end

    // FSM state register.
    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            state  <= StIdle;
            gapCnt <= '0;
        end else begin
            state  <= stateNext;
            gapCnt <= gapCntNext;
        end
    end

    // FSM next state: only a committed internal write opens a gap.
    always_comb begin
        stateNext  = state;
        gapCntNext = gapCnt;
        case (state)
            StIdle: begin
                if (selValid && !selAbort && (GAP != 0)) begin
                    stateNext  = StGap;
                    gapCntNext = GapLoad;
                end
            end
            StGap: begin
                if (gapCnt == '0) begin
                    stateNext = StIdle;
                end else begin
                    gapCntNext = gapCnt - 1'b1;
                end
            end
            default: stateNext = StIdle;
        endcase
    end

    // FSM outputs: next values of the registered write port, Gnt/Abort, pointer, conflicts.
    always_comb begin
        regWrNext   = 1'b0;
        regAddrNext = regAddrQ;
        regDataNext = regDataQ;
        gntNext     = '0;
        abortNext   = '0;
        ptrNext     = ptr;

        // A host write to an address a pending requester targets marks it stale.
        hostHit[0] = bus.HostWr && (bus.HostAddr == bus.ReqAddr0) && bus.Req[0] && !gntQ[0];
        hostHit[1] = bus.HostWr && (bus.HostAddr == bus.ReqAddr1) && bus.Req[1] && !gntQ[1];
        confNext   = bus.Req & (conf | hostHit);

        if (bus.HostWr) begin
            regWrNext   = 1'b1;
            regAddrNext = bus.HostAddr;
            regDataNext = bus.HostData;
        end else if (selValid) begin
            gntNext[sel] = 1'b1;
            ptrNext      = ~sel;
            if (selAbort) begin
                abortNext[sel] = 1'b1;
                confNext[sel]  = 1'b0;
            end else begin
                regWrNext   = 1'b1;
                regAddrNext = sel ? bus.ReqAddr1 : bus.ReqAddr0;
                regDataNext = sel ? bus.ReqData1 : bus.ReqData0;
            end
        end
    end

    // Registered outputs and arbitration state.
    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            regWrQ   <= 1'b0;
            regAddrQ <= '0;
            regDataQ <= '0;
            gntQ     <= '0;
            abortQ   <= '0;
            ptr      <= 1'b0;
            conf     <= '0;
        end else begin
            regWrQ   <= regWrNext;
            regAddrQ <= regAddrNext;
            regDataQ <= regDataNext;
            gntQ     <= gntNext;
            abortQ   <= abortNext;
            ptr      <= ptrNext;
            conf     <= confNext;
        end
    end

    assign bus.RegWr   = regWrQ;
    assign bus.RegAddr = regAddrQ;
    assign bus.RegData = regDataQ;
    assign bus.Gnt     = gntQ;
    assign bus.Abort   = abortQ;

endmodule

// File: tb/tb_lpc_reg_wr_arb.sv
// Purpose: directed, table-driven check of lpc_reg_wr_arb (GAP=1 instance) plus
//          hand sequences for mid-operation reset and a GAP=0 instance.
module tb_lpc_reg_wr_arb;

    logic LpcClock;
    logic PciReset;

    lpc_reg_wr_arb_if bus1();
    lpc_reg_wr_arb_if bus0();

    lpc_reg_wr_arb #(.GAP(1)) dut1 (
        .LpcClock (LpcClock),
        .PciReset (PciReset),
        .bus      (bus1.slave)
    );

    lpc_reg_wr_arb #(.GAP(0)) dut0 (
        .LpcClock (LpcClock),
        .PciReset (PciReset),
        .bus      (bus0.slave)
    );

    initial LpcClock = 1'b0;
    always #5 LpcClock = ~LpcClock;

    typedef struct {
        logic       hw;
        logic [7:0] ha;
        logic [7:0] hd;
        logic [1:0] req;
        logic [7:0] a0;
        logic [7:0] d0;
        logic [7:0] a1;
        logic [7:0] d1;
        logic       eWr;
        logic [7:0] eAddr;
        logic [7:0] eData;
        logic [1:0] eGnt;
        logic [1:0] eAbort;
    } vec_t;

    vec_t vecs[$];
    int   nCompared;
    int   nMismatch;
    int   gntPulses;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic drive1(input logic hw, input logic [7:0] ha, input logic [7:0] hd,
                          input logic [1:0] req, input logic [7:0] a0, input logic [7:0] d0,
                          input logic [7:0] a1, input logic [7:0] d1);
        bus1.HostWr   = hw;
        bus1.HostAddr = ha;
        bus1.HostData = hd;
        bus1.Req      = req;
        bus1.ReqAddr0 = a0;
        bus1.ReqData0 = d0;
        bus1.ReqAddr1 = a1;
        bus1.ReqData1 = d1;
    endtask

    task automatic drive0(input logic [1:0] req, input logic [7:0] a0, input logic [7:0] d0,
                          input logic [7:0] a1, input logic [7:0] d1);
        bus0.HostWr   = 1'b0;
        bus0.HostAddr = 8'h00;
        bus0.HostData = 8'h00;
        bus0.Req      = req;
        bus0.ReqAddr0 = a0;
        bus0.ReqData0 = d0;
        bus0.ReqAddr1 = a1;
        bus0.ReqData1 = d1;
    endtask

    task automatic chkZero1(input string tag);
        chk({tag, " RegWr"},   8'(bus1.RegWr), 8'h00);
        chk({tag, " RegAddr"}, bus1.RegAddr,   8'h00);
        chk({tag, " RegData"}, bus1.RegData,   8'h00);
        chk({tag, " Gnt"},     8'(bus1.Gnt),   8'h00);
        chk({tag, " Abort"},   8'(bus1.Abort), 8'h00);
    endtask

    initial begin
        nCompared = 0;
        nMismatch = 0;
        gntPulses = 0;
        PciReset  = 1'b0;
        drive1(1'b0, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        drive0(2'b00, 8'h00, 8'h00, 8'h00, 8'h00);

        //             hw    ha     hd     req    a0     d0     a1     d1     eWr   eAddr  eData  eGnt   eAbort
        vecs.push_back('{1'b1, 8'h0B, 8'h5A, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'h0B, 8'h5A, 2'b00, 2'b00});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h0B, 8'h5A, 2'b00, 2'b00});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 2'b11, 8'h10, 8'hA0, 8'h20, 8'hB1, 1'b1, 8'h10, 8'hA0, 2'b01, 2'b00});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 2'b11, 8'h10, 8'hA0, 8'h20, 8'hB1, 1'b0, 8'h10, 8'hA0, 2'b00, 2'b00});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 2'b10, 8'h10, 8'hA0, 8'h20, 8'hB1, 1'b1, 8'h20, 8'hB1, 2'b10, 2'b00});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 2'b10, 8'h10, 8'hA0, 8'h20, 8'hB1, 1'b0, 8'h20, 8'hB1, 2'b00, 2'b00});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 2'b00, 8'h10, 8'hA0, 8'h20, 8'hB1, 1'b0, 8'h20, 8'hB1, 2'b00, 2'b00});
        vecs.push_back('{1'b1, 8'h01, 8'h77, 2'b01, 8'h01, 8'hC3, 8'h00, 8'h00, 1'b1, 8'h01, 8'h77, 2'b00, 2'b00});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 2'b01, 8'h01, 8'hC3, 8'h00, 8'h00, 1'b0, 8'h01, 8'h77, 2'b01, 2'b01});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 2'b00, 8'h01, 8'hC3, 8'h00, 8'h00, 1'b0, 8'h01, 8'h77, 2'b00, 2'b00});
        vecs.push_back('{1'b1, 8'h07, 8'h88, 2'b10, 8'h00, 8'h00, 8'h03, 8'hD4, 1'b1, 8'h07, 8'h88, 2'b00, 2'b00});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 2'b10, 8'h00, 8'h00, 8'h03, 8'hD4, 1'b1, 8'h03, 8'hD4, 2'b10, 2'b00});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 2'b10, 8'h00, 8'h00, 8'h03, 8'hD4, 1'b0, 8'h03, 8'hD4, 2'b00, 2'b00});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 8'h03, 8'hD4, 1'b0, 8'h03, 8'hD4, 2'b00, 2'b00});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 2'b01, 8'h40, 8'hE5, 8'h00, 8'h00, 1'b1, 8'h40, 8'hE5, 2'b01, 2'b00});
        vecs.push_back('{1'b1, 8'h55, 8'h66, 2'b01, 8'h40, 8'hE5, 8'h00, 8'h00, 1'b1, 8'h55, 8'h66, 2'b00, 2'b00});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 2'b00, 8'h40, 8'hE5, 8'h00, 8'h00, 1'b0, 8'h55, 8'h66, 2'b00, 2'b00});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 2'b11, 8'h40, 8'hE5, 8'h20, 8'hB1, 1'b1, 8'h20, 8'hB1, 2'b10, 2'b00});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 2'b11, 8'h40, 8'hE5, 8'h20, 8'hB1, 1'b0, 8'h20, 8'hB1, 2'b00, 2'b00});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 2'b01, 8'h40, 8'hE5, 8'h20, 8'hB1, 1'b1, 8'h40, 8'hE5, 2'b01, 2'b00});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 2'b01, 8'h40, 8'hE5, 8'h20, 8'hB1, 1'b0, 8'h40, 8'hE5, 2'b00, 2'b00});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 2'b00, 8'h40, 8'hE5, 8'h20, 8'hB1, 1'b0, 8'h40, 8'hE5, 2'b00, 2'b00});
        vecs.push_back('{1'b1, 8'h03, 8'h99, 2'b10, 8'h00, 8'h00, 8'h03, 8'hD4, 1'b1, 8'h03, 8'h99, 2'b00, 2'b00});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 8'h03, 8'hD4, 1'b0, 8'h03, 8'h99, 2'b00, 2'b00});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 2'b10, 8'h00, 8'h00, 8'h03, 8'hD4, 1'b1, 8'h03, 8'hD4, 2'b10, 2'b00});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 2'b10, 8'h00, 8'h00, 8'h03, 8'hD4, 1'b0, 8'h03, 8'hD4, 2'b00, 2'b00});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 8'h03, 8'hD4, 1'b0, 8'h03, 8'hD4, 2'b00, 2'b00});

        // Reset values on both instances.
        @(negedge LpcClock);
        @(negedge LpcClock);
        chkZero1("reset");
        chk("reset g0 RegWr", 8'(bus0.RegWr), 8'h00);
        chk("reset g0 Gnt",   8'(bus0.Gnt),   8'h00);
        PciReset = 1'b1;

        // Table: inputs applied on a falling edge, outputs checked one cycle later.
        for (int i = 0; i < vecs.size(); i++) begin
            drive1(vecs[i].hw, vecs[i].ha, vecs[i].hd, vecs[i].req,
                   vecs[i].a0, vecs[i].d0, vecs[i].a1, vecs[i].d1);
            @(negedge LpcClock);
            chk($sformatf("v%0d RegWr", i),   8'(bus1.RegWr), 8'(vecs[i].eWr));
            chk($sformatf("v%0d RegAddr", i), bus1.RegAddr,   vecs[i].eAddr);
            chk($sformatf("v%0d RegData", i), bus1.RegData,   vecs[i].eData);
            chk($sformatf("v%0d Gnt", i),     8'(bus1.Gnt),   8'(vecs[i].eGnt));
            chk($sformatf("v%0d Abort", i),   8'(bus1.Abort), 8'(vecs[i].eAbort));
        end

        // Reset right after a selection of requester 0 (which moved the pointer to 1).
        drive1(1'b0, 8'h00, 8'h00, 2'b11, 8'h10, 8'hA0, 8'h20, 8'hB1);
        @(posedge LpcClock);
        #1 PciReset = 1'b0;
        @(negedge LpcClock);
        chkZero1("midrst");
        @(negedge LpcClock);
        PciReset = 1'b1;
        @(negedge LpcClock);
        chk("postrst Gnt",     8'(bus1.Gnt), 8'h01);
        chk("postrst RegAddr", bus1.RegAddr, 8'h10);
        chk("postrst RegData", bus1.RegData, 8'hA0);
        drive1(1'b0, 8'h00, 8'h00, 2'b10, 8'h10, 8'hA0, 8'h20, 8'hB1);
        @(negedge LpcClock);
        chk("postrst gap Gnt", 8'(bus1.Gnt), 8'h00);
        @(negedge LpcClock);
        chk("postrst r1 Gnt",     8'(bus1.Gnt), 8'h02);
        chk("postrst r1 RegAddr", bus1.RegAddr, 8'h20);
        drive1(1'b0, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge LpcClock);

        // GAP=0: Req[0] held through its Gnt cycle gives one pulse.
        drive0(2'b01, 8'h21, 8'hF0, 8'h31, 8'h0F);
        @(negedge LpcClock);
        if (bus0.Gnt[0]) gntPulses++;
        chk("g0 first Gnt",     8'(bus0.Gnt),   8'h01);
        chk("g0 first RegWr",   8'(bus0.RegWr), 8'h01);
        chk("g0 first RegAddr", bus0.RegAddr,   8'h21);
        @(negedge LpcClock);
        if (bus0.Gnt[0]) gntPulses++;
        chk("g0 held Gnt",   8'(bus0.Gnt),   8'h00);
        chk("g0 held RegWr", 8'(bus0.RegWr), 8'h00);
        drive0(2'b00, 8'h21, 8'hF0, 8'h31, 8'h0F);
        @(negedge LpcClock);
        if (bus0.Gnt[0]) gntPulses++;
        chk("g0 pulse count", 8'(gntPulses), 8'h01);

        // GAP=0 back-to-back: pointer is 1, so requester 1 first, then requester 0.
        drive0(2'b11, 8'h21, 8'hF0, 8'h31, 8'h0F);
        @(negedge LpcClock);
        chk("g0 b2b r1 Gnt",     8'(bus0.Gnt), 8'h02);
        chk("g0 b2b r1 RegData", bus0.RegData, 8'h0F);
        @(negedge LpcClock);
        chk("g0 b2b r0 Gnt",     8'(bus0.Gnt), 8'h01);
        chk("g0 b2b r0 RegData", bus0.RegData, 8'hF0);
        drive0(2'b01, 8'h21, 8'hF0, 8'h31, 8'h0F);
        @(negedge LpcClock);
        chk("g0 b2b end Gnt",   8'(bus0.Gnt),   8'h00);
        chk("g0 b2b end RegWr", 8'(bus0.RegWr), 8'h00);
        drive0(2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge LpcClock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
